// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that assembles NUM_BYTES consecutive bytes into one word,
// first byte in bits [7:0]; reports framing errors and inter-byte timeouts.
module uart_frame_rx #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned NUM_BYTES = 5,
  parameter int unsigned TIMEOUT   = 20 * BAUD_DIV
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [8*NUM_BYTES-1:0] rx_data,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   rx_timeout,
  output logic                   busy
);

  localparam int unsigned W  = 8 * NUM_BYTES;
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    NB3       = 3'(NUM_BYTES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          sync1, sync2, prev;
  logic          fall;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [2:0]    byte_cnt, byte_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [7:0]    byte_sr, sr_n;
  logic [W-1:0]  shift_reg, shift_n;
  logic [W-1:0]  data_n;
  logic          done, done_n;
  logic          valid_n, err_n, tmo_p_n;

  assign fall = prev & ~sync2;
  assign busy = (state != IDLE) || (byte_cnt != '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      byte_sr     <= '0;
      shift_reg   <= '0;
      done        <= 1'b0;
      rx_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      rx_timeout  <= 1'b0;
    end else begin
      sync1       <= uart_rx;
      sync2       <= sync1;
      prev        <= sync2;
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_cnt     <= bit_n;
      byte_cnt    <= byte_n;
      tmo_cnt     <= tmo_n;
      byte_sr     <= sr_n;
      shift_reg   <= shift_n;
      done        <= done_n;
      rx_data     <= data_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
      rx_timeout  <= tmo_p_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    tmo_n   = tmo_cnt;
    sr_n    = byte_sr;
    shift_n = shift_reg;
    done_n  = 1'b0;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    tmo_p_n = 1'b0;

    // Frame completion is published one cycle after the last stop sample.
    if (done) begin
      data_n  = shift_reg;
      valid_n = 1'b1;
      byte_n  = '0;
      shift_n = '0;
    end

    case (state)
      IDLE: begin
        // Timeout is resolved before a same-cycle start, so that byte becomes byte 0.
        if (byte_cnt != '0 && !done) begin
          if (tmo_cnt == TMO_LAST) begin
            byte_n  = '0;
            shift_n = '0;
            tmo_p_n = 1'b1;
            tmo_n   = '0;
          end else begin
            tmo_n = tmo_cnt + TW'(1);
          end
        end else begin
          tmo_n = '0;
        end
        if (fall) begin
          state_n = START;
          baud_n  = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_n = '0;
          if (!sync2) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          sr_n   = {sync2, byte_sr[7:1]};
          bit_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          state_n = IDLE;
          tmo_n   = '0;
          if (sync2) begin
            // Shift via a widened concat so NUM_BYTES=1 needs no empty slice.
            shift_n = W'({byte_sr, shift_reg} >> 8);
            byte_n  = byte_cnt + 3'd1;
            if (byte_cnt + 3'd1 == NB3) done_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            byte_n  = '0;
            shift_n = '0;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed and randomized bench for uart_frame_rx; a queue-based frame model
// predicts assembled words, error and timeout counts.
module tb_uart_frame_rx;
  localparam int unsigned BAUD = 16;
  localparam int unsigned NB   = 5;
  localparam int unsigned TMO  = 20 * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [39:0] rx_data;
  logic        frame_valid, frame_err, rx_timeout, busy;

  int vectors = 0;
  int miscompares = 0;

  // observed activity
  logic [39:0] got_q[$];
  int          t_q[$];
  int          n_err = 0, n_tmo = 0, n_excl = 0, cyc = 0;

  // reference model state
  logic [7:0]  part_q[$];
  logic [39:0] exp_q[$];
  int          e_err = 0, e_tmo = 0;
  logic [39:0] exp_last = '0;

  uart_frame_rx #(.BAUD_DIV(BAUD), .NUM_BYTES(NB), .TIMEOUT(TMO)) dut (
    .sys_clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
    .frame_valid(frame_valid), .frame_err(frame_err), .rx_timeout(rx_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      got_q.push_back(rx_data);
      t_q.push_back(cyc);
    end
    if (frame_err) n_err++;
    if (rx_timeout) n_tmo++;
    if (int'(frame_valid) + int'(frame_err) + int'(rx_timeout) > 1) n_excl++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [39:0] w;
    uart_rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BAUD);
    end
    uart_rx = stop_ok;
    tick(BAUD);
    uart_rx = 1'b1;
    if (stop_ok) begin
      part_q.push_back(b);
      if (part_q.size() == NB) begin
        w = '0;
        for (int k = 0; k < NB; k++) w = w | (40'(part_q[k]) << (8 * k));
        exp_q.push_back(w);
        exp_last = w;
        part_q.delete();
      end
    end else begin
      e_err++;
      part_q.delete();
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    tick(n);
    if (n > TMO && part_q.size() > 0) begin
      e_tmo++;
      part_q.delete();
    end
  endtask

  task automatic send_frame(input logic [39:0] w);
    for (int k = 0; k < NB; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".frames"}, 64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, ".rx_data"}, 64'(rx_data), 64'(exp_last));
    chk({tag, ".errs"}, 64'(n_err), 64'(e_err));
    chk({tag, ".tmos"}, 64'(n_tmo), 64'(e_tmo));
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         t0;

    tick(3);
    chk("rst.rx_data", 64'(rx_data), 64'h0);
    chk("rst.valid", 64'(frame_valid), 64'h0);
    chk("rst.err", 64'(frame_err), 64'h0);
    chk("rst.tmo", 64'(rx_timeout), 64'h0);
    chk("rst.busy", 64'(busy), 64'h0);
    rst = 1'b0;
    idle(20);
    chk("idle.busy", 64'(busy), 64'h0);

    send_frame(40'h5544332211);
    idle(10);
    check_all("basic");
    chk("basic.word", 64'(rx_data), 64'h5544332211);

    uart_rx = 1'b0;
    tick(4);
    idle(40);
    chk("glitch.busy", 64'(busy), 64'h0);
    check_all("glitch");
    send_frame(40'h0504030201);
    idle(10);
    check_all("after_glitch");
    chk("after_glitch.word", 64'(rx_data), 64'h0504030201);

    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h99, 1'b0);
    idle(20);
    check_all("stop_err");
    chk("stop_err.hold", 64'(rx_data), 64'h0504030201);
    send_frame(40'hE5D4C3B2A1);
    idle(10);
    check_all("after_err");
    chk("after_err.word", 64'(rx_data), 64'hE5D4C3B2A1);

    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle(TMO + 5);
    check_all("timeout");
    chk("timeout.count", 64'(n_tmo), 64'd1);
    send_frame(40'h5040302010);
    idle(10);
    check_all("after_tmo");
    chk("after_tmo.word", 64'(rx_data), 64'h5040302010);

    send_byte(8'h5A, 1'b1);
    uart_rx = 1'b0;
    tick(3 * BAUD);
    chk("midbyte.busy", 64'(busy), 64'h1);
    rst = 1'b1;
    uart_rx = 1'b1;
    #1;
    chk("rst2.rx_data", 64'(rx_data), 64'h0);
    chk("rst2.busy", 64'(busy), 64'h0);
    chk("rst2.pulses", 64'({frame_valid, frame_err, rx_timeout}), 64'h0);
    tick(3);
    rst = 1'b0;
    part_q.delete();
    exp_last = '0;
    idle(20);
    send_frame(40'hFF00FF00FF);
    idle(10);
    check_all("after_rst");
    chk("after_rst.word", 64'(rx_data), 64'hFF00FF00FF);

    t0 = t_q.size();
    send_frame(40'h1122334455);
    send_frame(40'h66778899AA);
    idle(10);
    check_all("b2b");
    chk("b2b.count", 64'(t_q.size() - t0), 64'd2);
    if (t_q.size() - t0 >= 2)
      chk("b2b.spacing", 64'(t_q[t_q.size()-1] - t_q[t_q.size()-2]), 64'(50 * BAUD));

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NB; k++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 9) != 0);
        send_byte(b, ok);
        if (ok) idle($urandom_range(0, 3));
        else idle($urandom_range(3, 30));
      end
    end
    idle(TMO + 5);
    check_all("random");
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("frame%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    chk("exclusive", 64'(n_excl), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
